// File: rtl/dram_uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : dram_uart_tx_if
//  Brief    : Bundle of the start handshake, DRAM read port and UART line
//             used by dram_uart_tx.
//             master : processor / DRAM side (drives start and read data)
//             slave  : the transmitter (drives address, status and Tx)
//  Revision : 1.0  initial release
// ============================================================================
interface dram_uart_tx_if;
  logic        start_Tx;
  logic [7:0]  DRAM_input_data;
  logic [15:0] DRAM_address_tx;
  logic        tx_busy;
  logic        tx_done;
  logic        Tx;

  modport master (
    output start_Tx,
    output DRAM_input_data,
    input  DRAM_address_tx,
    input  tx_busy,
    input  tx_done,
    input  Tx
  );

  modport slave (
    input  start_Tx,
    input  DRAM_input_data,
    output DRAM_address_tx,
    output tx_busy,
    output tx_done,
    output Tx
  );
endinterface
`default_nettype wire

// File: rtl/dram_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : dram_uart_tx
//  Brief    : On start_Tx, reads NUM_BYTES bytes from DRAM starting at
//             START_ADDR and sends each as an 8N1 UART frame, LSB first.
//             Owns the DRAM address mux input while tx_busy is high.
//             Optional macro TX_PARITY_EN adds an even-parity bit between
//             the data bits and the stop bit.
//  Revision : 1.0  initial release
// ============================================================================
module dram_uart_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [15:0] START_ADDR   = 16'h0000,
  parameter logic [15:0] NUM_BYTES    = 16'd256
) (
  input wire            clock,
  input wire            reset,
  dram_uart_tx_if.slave bus_io
);

  localparam int                 c_CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ADDR   = 4'd1,
    S_LOAD   = 4'd2,
    S_START  = 4'd3,
    S_DATA   = 4'd4,
    S_STOP   = 4'd5,
    S_NEXT   = 4'd6,
    S_DONE   = 4'd7
`ifdef TX_PARITY_EN
    , S_PARITY = 4'd8
`endif
  } state_t;

  state_t             state_q;
  logic [c_CNT_W-1:0] cnt_q;
  logic [2:0]         bit_q;
  logic [15:0]        idx_q;
  logic [7:0]         shift_q;
  logic [15:0]        addr_q;
  logic               tx_q;
  logic               busy_q;
  logic               done_q;

  // Index and address of the byte that follows the current one; the 16-bit
  // add wraps 16'hFFFF to 16'h0000 naturally.
  logic [15:0] idx_d;
  logic [15:0] addr_d;
  logic        w_baud_tick;

  assign idx_d       = idx_q + 16'd1;
  assign addr_d      = START_ADDR + idx_d;
  assign w_baud_tick = (cnt_q == c_CNT_MAX);

  // Transfer sequencer: Tx is registered from the current state, so the line
  // trails the state by one cycle and never glitches.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      idx_q   <= 16'd0;
      shift_q <= 8'd0;
      addr_q  <= START_ADDR;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= bus_io.start_Tx;
          if (bus_io.start_Tx) begin
            // Present the address during ADDR so read data is ready in LOAD.
            addr_q  <= START_ADDR + idx_q;
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          tx_q  <= 1'b1;
          cnt_q <= '0;
          bit_q <= 3'd0;
          if (NUM_BYTES == 16'd0) begin
            state_q <= S_DONE;
          end else begin
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          tx_q    <= 1'b1;
          shift_q <= bus_io.DRAM_input_data;
          state_q <= S_START;
        end
        S_START: begin
          tx_q <= 1'b0;
          if (w_baud_tick) begin
            cnt_q   <= '0;
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + c_CNT_W'(1);
          end
        end
        S_DATA: begin
          tx_q <= shift_q[bit_q];
          if (w_baud_tick) begin
            cnt_q <= '0;
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef TX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + c_CNT_W'(1);
          end
        end
`ifdef TX_PARITY_EN
        S_PARITY: begin
          tx_q <= ^shift_q;
          if (w_baud_tick) begin
            cnt_q   <= '0;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + c_CNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          tx_q <= 1'b1;
          if (w_baud_tick) begin
            cnt_q   <= '0;
            state_q <= S_NEXT;
          end else begin
            cnt_q <= cnt_q + c_CNT_W'(1);
          end
        end
        S_NEXT: begin
          tx_q  <= 1'b1;
          idx_q <= idx_d;
          if (idx_d == NUM_BYTES) begin
            state_q <= S_DONE;
          end else begin
            addr_q  <= addr_d;
            state_q <= S_ADDR;
          end
        end
        S_DONE: begin
          // busy stays high through this edge and drops in IDLE unless a new
          // request is already waiting.
          tx_q    <= 1'b1;
          done_q  <= 1'b1;
          idx_q   <= 16'd0;
          state_q <= S_IDLE;
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus_io.DRAM_address_tx = addr_q;
  assign bus_io.tx_busy         = busy_q;
  assign bus_io.tx_done         = done_q;
  assign bus_io.Tx              = tx_q;

endmodule
`default_nettype wire
